// File: rtl/pll_md_pkg.sv
// Shared opcodes, FSM states and error codes for the PLL dynamic-reconfiguration controller.
package pll_md_pkg;

  typedef enum logic [1:0] {
    OPC_NOP  = 2'b00,
    OPC_ADDR = 2'b01,
    OPC_WR   = 2'b10,
    OPC_RD   = 2'b11
  } md_opc_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_GAP,
    S_WR,
    S_RADDR,
    S_RD,
    S_CHK,
    S_RST,
    S_LOCK
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_MDIV  = 2'd1,
    ERR_ODIV0 = 2'd2,
    ERR_LOCK  = 2'd3
  } err_code_e;

  localparam logic [7:0] ADDR_MDIV_DEF    = 8'h00;
  localparam logic [7:0] ADDR_ODIV0_DEF   = 8'h01;
  localparam int         RST_CYCLES_DEF   = 16;
  localparam int         LOCK_STABLE_DEF  = 64;
  localparam int         LOCK_TIMEOUT_DEF = 65535;

  // Counter width able to hold the terminal value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pll_md_lockmon.sv
// PLL lock monitor: two-flop synchroniser plus saturating stable-run and timeout counters.
module pll_md_lockmon
  import pll_md_pkg::*;
#(
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lock_async,
  output logic stable,
  output logic timeout
);

  localparam int SW = cnt_w(LOCK_STABLE);
  localparam int TW = cnt_w(LOCK_TIMEOUT);

  logic [1:0]    sync_reg;
  logic [SW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg       <= 2'b00;
      stable_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
    end else begin
      sync_reg       <= {sync_reg[0], lock_async};
      stable_cnt_reg <= stable_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
    end
  end

  // Counters are held clear outside the wait window so every wait starts from zero.
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    if (!start) begin
      stable_cnt_next = '0;
      tmo_cnt_next    = '0;
    end else begin
      if (!sync_reg[1]) begin
        stable_cnt_next = '0;
      end else if (stable_cnt_reg != SW'(LOCK_STABLE)) begin
        stable_cnt_next = stable_cnt_reg + SW'(1);
      end
      if (tmo_cnt_reg != TW'(LOCK_TIMEOUT)) begin
        tmo_cnt_next = tmo_cnt_reg + TW'(1);
      end
    end
  end

  assign stable  = (stable_cnt_reg == SW'(LOCK_STABLE));
  assign timeout = (tmo_cnt_reg == TW'(LOCK_TIMEOUT));

endmodule

// File: rtl/pll_md_ctrl.sv
// Retune controller for the pixel-clock PLL: writes and verifies MDIV/ODIV0 over the
// MD port, pulses the PLL reset, then waits for a stable lock before reporting done.
module pll_md_ctrl
  import pll_md_pkg::*;
#(
  parameter logic [7:0] ADDR_MDIV    = ADDR_MDIV_DEF,
  parameter logic [7:0] ADDR_ODIV0   = ADDR_ODIV0_DEF,
  parameter int         RST_CYCLES   = RST_CYCLES_DEF,
  parameter int         LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int         LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_mdiv,
  input  logic [7:0] req_odiv0,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int RW = cnt_w(RST_CYCLES);

  state_e        state_reg, state_next;
  state_e        ret_reg, ret_next;
  logic          sel_reg, sel_next;
  logic [7:0]    mdiv_reg, mdiv_next;
  logic [7:0]    odiv_reg, odiv_next;
  logic [RW-1:0] rst_cnt_reg, rst_cnt_next;
  err_code_e     err_code_reg, err_code_next;

  logic       lock_run;
  logic       lock_stable;
  logic       lock_timeout;
  logic [7:0] cur_addr;
  logic [7:0] cur_code;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      ret_reg      <= S_IDLE;
      sel_reg      <= 1'b0;
      mdiv_reg     <= 8'h00;
      odiv_reg     <= 8'h00;
      rst_cnt_reg  <= '0;
      err_code_reg <= ERR_NONE;
    end else begin
      state_reg    <= state_next;
      ret_reg      <= ret_next;
      sel_reg      <= sel_next;
      mdiv_reg     <= mdiv_next;
      odiv_reg     <= odiv_next;
      rst_cnt_reg  <= rst_cnt_next;
      err_code_reg <= err_code_next;
    end
  end

  // sel_reg picks which divider register the current MD pass is working on.
  assign cur_addr = sel_reg ? ADDR_ODIV0 : ADDR_MDIV;
  assign cur_code = sel_reg ? odiv_reg : mdiv_reg;
  assign md_ainc  = 1'b0;
  assign lock_run = (state_reg == S_LOCK);

  always_comb begin
    state_next    = state_reg;
    ret_next      = ret_reg;
    sel_next      = sel_reg;
    mdiv_next     = mdiv_reg;
    odiv_next     = odiv_reg;
    rst_cnt_next  = rst_cnt_reg;
    err_code_next = err_code_reg;
    md_opc        = OPC_NOP;
    md_wdi        = 8'h00;
    pll_reset     = 1'b0;
    busy          = 1'b1;
    req_ready     = 1'b0;
    done          = 1'b0;
    err           = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          mdiv_next     = req_mdiv;
          odiv_next     = req_odiv0;
          sel_next      = 1'b0;
          err_code_next = ERR_NONE;
          state_next    = S_ADDR;
        end
      end
      S_ADDR: begin
        md_opc     = OPC_ADDR;
        md_wdi     = cur_addr;
        ret_next   = S_WR;
        state_next = S_GAP;
      end
      S_WR: begin
        md_opc     = OPC_WR;
        md_wdi     = cur_code;
        ret_next   = S_RADDR;
        state_next = S_GAP;
      end
      S_RADDR: begin
        md_opc     = OPC_ADDR;
        md_wdi     = cur_addr;
        ret_next   = S_RD;
        state_next = S_GAP;
      end
      S_RD: begin
        md_opc     = OPC_RD;
        md_wdi     = cur_addr;
        ret_next   = S_CHK;
        state_next = S_GAP;
      end
      S_GAP: begin
        state_next = ret_reg;
      end
      S_CHK: begin
        // A failed readback leaves the PLL untouched so the old clock keeps running.
        if (md_rdo != cur_code) begin
          err        = 1'b1;
          state_next = S_IDLE;
          if (sel_reg) begin
            err_code_next = ERR_ODIV0;
          end else begin
            err_code_next = ERR_MDIV;
          end
        end else if (!sel_reg) begin
          sel_next   = 1'b1;
          state_next = S_ADDR;
        end else begin
          rst_cnt_next = '0;
          state_next   = S_RST;
        end
      end
      S_RST: begin
        pll_reset = 1'b1;
        if (rst_cnt_reg == RW'(RST_CYCLES - 1)) begin
          state_next = S_LOCK;
        end else begin
          rst_cnt_next = rst_cnt_reg + RW'(1);
        end
      end
      S_LOCK: begin
        // Stable lock takes priority over a simultaneous timeout.
        if (lock_stable) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (lock_timeout) begin
          err           = 1'b1;
          err_code_next = ERR_LOCK;
          state_next    = S_IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  // The fresh code is visible alongside the err pulse, then held until the next accept.
  assign err_code = err ? err_code_next : err_code_reg;

  pll_md_lockmon #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lockmon (
    .clk       (clkin),
    .rst       (reset),
    .start     (lock_run),
    .lock_async(pll_lock),
    .stable    (lock_stable),
    .timeout   (lock_timeout)
  );

endmodule

// File: tb/tb_pll_md_ctrl.sv
// Self-checking bench for pll_md_ctrl: an MD register-file model of the PLL plus a
// cycle-indexed reference for op sequence, reset pulse and lock outcome.
module tb_pll_md_ctrl;
  import pll_md_pkg::*;

  localparam int R  = 16;
  localparam int S  = 64;
  localparam int TA = 65535;
  localparam int TB = 100;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_mdiv = 8'h00;
  logic [7:0] req_odiv0 = 8'h00;
  logic [7:0] md_rdo;
  logic       pll_lock = 1'b0;

  logic       a_req_ready, a_md_ainc, a_pll_reset, a_busy, a_done, a_err;
  logic [1:0] a_md_opc, a_err_code;
  logic [7:0] a_md_wdi;
  logic       b_req_ready, b_md_ainc, b_pll_reset, b_busy, b_done, b_err;
  logic [1:0] b_md_opc, b_err_code;
  logic [7:0] b_md_wdi;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clkin = ~clkin;

  pll_md_ctrl #(.RST_CYCLES(R), .LOCK_STABLE(S), .LOCK_TIMEOUT(TA)) dut_a (
    .clkin(clkin), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_mdiv(req_mdiv), .req_odiv0(req_odiv0), .md_opc(a_md_opc), .md_ainc(a_md_ainc),
    .md_wdi(a_md_wdi), .md_rdo(md_rdo), .pll_reset(a_pll_reset), .pll_lock(pll_lock),
    .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_err_code)
  );

  pll_md_ctrl #(.RST_CYCLES(R), .LOCK_STABLE(S), .LOCK_TIMEOUT(TB)) dut_b (
    .clkin(clkin), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_mdiv(req_mdiv), .req_odiv0(req_odiv0), .md_opc(b_md_opc), .md_ainc(b_md_ainc),
    .md_wdi(b_md_wdi), .md_rdo(md_rdo), .pll_reset(b_pll_reset), .pll_lock(pll_lock),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code)
  );

  // PLL MD register file; fault_reg selects a register whose readback returns bad_val.
  logic [7:0] pm_regs [0:255];
  logic [7:0] pm_addr;
  int         fault_reg = 0;
  logic [7:0] bad_val = 8'h00;

  always @(posedge clkin) begin
    case (a_md_opc)
      2'b01: pm_addr <= a_md_wdi;
      2'b10: pm_regs[pm_addr] <= a_md_wdi;
      2'b11: md_rdo <= ((fault_reg == 1 && pm_addr == 8'h00) ||
                        (fault_reg == 2 && pm_addr == 8'h01)) ? bad_val : pm_regs[pm_addr];
      default: ;
    endcase
  end

  task automatic chk(input string name, input string fld, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s cycle %0d: observed %0h expected %0h", name, fld, k, obs, exp);
    end
  endtask

  function automatic bit lk_val(input int k, input int l0, input int on, input int glitch);
    if (on < 0) return 1'b0;
    if (k < l0 + on) return 1'b0;
    if (glitch >= 0 && k == l0 + glitch) return 1'b0;
    return 1'b1;
  endfunction

  // Expected {opc, wdi} in cycle k after accept: 9 cycles per register, ops on even slots.
  function automatic logic [9:0] exp_md(input int k, input logic [7:0] mdiv, input logic [7:0] odiv);
    int p;
    logic [7:0] a, c;
    if (k < 1 || k > 18) return 10'h000;
    p = (k - 1) % 9;
    a = (k > 9) ? 8'h01 : 8'h00;
    c = (k > 9) ? odiv : mdiv;
    case (p)
      0: return {2'b01, a};
      2: return {2'b10, c};
      4: return {2'b01, a};
      6: return {2'b11, a};
      default: return 10'h000;
    endcase
  endfunction

  // Walks the lock wait from S_LOCK entry: synchronised lock lags the pin by two cycles.
  task automatic lock_end(input int l0, input int on, input int glitch, input int tmo,
                          output int e, output bit ok);
    int st;
    bit fin;
    st = 0; fin = 0; e = l0 + tmo; ok = 0;
    for (int c = l0; c <= l0 + tmo && !fin; c++) begin
      if (st == S) begin
        e = c; ok = 1; fin = 1;
      end else if (c - l0 == tmo) begin
        e = c; ok = 0; fin = 1;
      end else begin
        st = lk_val(c - 2, l0, on, glitch) ? ((st < S) ? st + 1 : st) : 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clkin);
    reset = 1'b1; req_valid = 1'b0; pll_lock = 1'b0;
    #2;
    chk("reset", "ready", 0, a_req_ready, 1);
    chk("reset", "busy", 0, a_busy, 0);
    chk("reset", "done_err", 0, {a_done, a_err}, 0);
    chk("reset", "err_code", 0, a_err_code, 0);
    chk("reset", "prst", 0, a_pll_reset, 0);
    chk("reset", "md", 0, {a_md_opc, a_md_ainc, a_md_wdi}, 0);
    @(negedge clkin);
    @(negedge clkin);
    reset = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [7:0] mdiv, input logic [7:0] odiv,
                         input int fault, input logic [7:0] bad, input int lk_on, input int glitch,
                         input bit sel_b, input int abort_at, input bit busy_req);
    int e, l0, ecode;
    bit ok, aborted, exp_rst;
    logic [7:0] rd0, rd1, o_wdi;
    logic [1:0] o_opc, o_ecode;
    logic o_ainc, o_prst, o_busy, o_ready, o_done, o_err;
    fault_reg = fault; bad_val = bad; pll_lock = 1'b0; aborted = 0;
    rd0 = (fault == 1) ? bad : mdiv;
    rd1 = (fault == 2) ? bad : odiv;
    l0 = 19 + R;
    if (rd0 != mdiv) begin
      e = 9; ok = 0; ecode = 1;
    end else if (rd1 != odiv) begin
      e = 18; ok = 0; ecode = 2;
    end else begin
      lock_end(l0, lk_on, glitch, sel_b ? TB : TA, e, ok);
      ecode = ok ? 0 : 3;
    end
    @(negedge clkin);
    chk(name, "ready0", 0, sel_b ? b_req_ready : a_req_ready, 1);
    req_mdiv = mdiv; req_odiv0 = odiv; req_valid = 1'b1;
    for (int k = 1; k <= e + 1 && !aborted; k++) begin
      @(negedge clkin);
      o_opc   = sel_b ? b_md_opc : a_md_opc;
      o_wdi   = sel_b ? b_md_wdi : a_md_wdi;
      o_ainc  = sel_b ? b_md_ainc : a_md_ainc;
      o_prst  = sel_b ? b_pll_reset : a_pll_reset;
      o_busy  = sel_b ? b_busy : a_busy;
      o_ready = sel_b ? b_req_ready : a_req_ready;
      o_done  = sel_b ? b_done : a_done;
      o_err   = sel_b ? b_err : a_err;
      o_ecode = sel_b ? b_err_code : a_err_code;
      exp_rst = (ecode == 0 || ecode == 3) && k >= 19 && k < 19 + R;
      chk(name, "md", k, {o_opc, o_wdi}, (k <= e) ? exp_md(k, mdiv, odiv) : 10'h000);
      chk(name, "ainc", k, o_ainc, 0);
      chk(name, "prst", k, o_prst, exp_rst);
      chk(name, "busy", k, o_busy, (k <= e));
      chk(name, "ready", k, o_ready, (k > e));
      chk(name, "done", k, o_done, (k == e && ok));
      chk(name, "err", k, o_err, (k == e && !ok));
      if (k >= e) chk(name, "err_code", k, o_ecode, ecode);
      if (k == abort_at) begin
        #1 reset = 1'b1;
        #1;
        chk(name, "abort_prst", k, a_pll_reset, 0);
        chk(name, "abort_busy", k, a_busy, 0);
        chk(name, "abort_ready", k, a_req_ready, 1);
        @(negedge clkin);
        reset = 1'b0;
        aborted = 1;
      end
      pll_lock = lk_val(k, l0, lk_on, glitch);
      if (busy_req && k >= 2 && k <= 12) begin
        req_valid = 1'b1; req_mdiv = ~mdiv; req_odiv0 = ~odiv;
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    pll_lock = 1'b0;
  endtask

  initial begin
    logic [7:0] m, o, bad;
    int f, on, gl;
    bit sb;

    do_reset();
    run_txn("nominal", 8'h0E, 8'h23, 0, 8'h00, 10, -1, 0, -1, 0);
    do_reset();
    run_txn("rb_fault", 8'h0E, 8'h23, 2, 8'h22, 10, -1, 0, -1, 0);
    do_reset();
    run_txn("glitch", 8'h10, 8'h05, 0, 8'h00, 0, 40, 0, -1, 0);
    do_reset();
    run_txn("timeout", 8'h21, 8'h42, 0, 8'h00, -1, -1, 1, -1, 0);
    do_reset();
    run_txn("busy_req", 8'h3C, 8'h0A, 0, 8'h00, 5, -1, 0, -1, 1);
    do_reset();
    run_txn("abort", 8'h55, 8'hAA, 0, 8'h00, 2, -1, 0, 25, 0);
    run_txn("post_abort", 8'h12, 8'h34, 0, 8'h00, 3, -1, 0, -1, 0);

    for (int i = 0; i < 8; i++) begin
      m  = 8'($urandom_range(0, 255));
      o  = 8'($urandom_range(0, 255));
      f  = $urandom_range(0, 3);
      f  = (f == 3) ? 0 : f;
      bad = ((f == 1) ? m : o) ^ (8'h01 << $urandom_range(0, 7));
      sb = 1'($urandom_range(0, 1));
      on = (sb && $urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 20);
      gl = ($urandom_range(0, 1) == 1 && on >= 0) ? $urandom_range(on, on + 30) : -1;
      do_reset();
      run_txn($sformatf("rand%0d", i), m, o, f, bad, on, gl, sb, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
